alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two requesters.
//
// Flow: IDLE -> EXEC -> RESP -> IDLE, with one operation in flight at a time.
//  - IDLE: round-robin grant of one valid requester. reqN_ready is
//    combinational and the handshake is valid & ready in the same cycle.
//  - EXEC: alu_en high; control and operands come from registers captured at
//    the handshake. The state ends on the first cycle with alu_done high.
//  - RESP: a one-cycle rspN_valid pulse goes to the granted requester.
//    There is no backpressure.
// Illegal ops (4'b1010..4'b1111) skip EXEC and respond with err=1 and zero
// data. alu_en is low in IDLE and RESP, so there are always at least two
// en-low cycles between ALU operations.
//
// Optional feature (macro ALU_ARB_TIMEOUT_EN): abort EXEC after
// TIMEOUT_CYCLES cycles without alu_done. The response then has err=1 and
// all data zero. With the macro undefined, EXEC waits for alu_done
// indefinitely.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   reqN_valid/_ready         request handshake (N = 0, 1)
//   reqN_op/_a/_b             4-bit ALU control code and 32-bit operands
//   rspN_valid                one-cycle response pulse
//   rspN_result/_hi/_lo       response data, held between pulses
//   rspN_overflow/_zero/_err  response flags, held between pulses
//   alu_en                    high for the whole EXEC state
//   alu_control/_srcA/_srcB   registered op and operands to the ALU
//   alu_result, hi, lo        ALU results, captured on alu_done
//   overflow, alu_zero        ALU flags, captured on alu_done
//   alu_done                  ALU completion; ignored outside EXEC
module alu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  // response 0
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp0_hi,
  output logic [31:0] rsp0_lo,
  output logic        rsp0_overflow,
  output logic        rsp0_zero,
  output logic        rsp0_err,
  // response 1
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic [31:0] rsp1_hi,
  output logic [31:0] rsp1_lo,
  output logic        rsp1_overflow,
  output logic        rsp1_zero,
  output logic        rsp1_err,
  // ALU side
  output logic        alu_en,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  input  logic [31:0] alu_result,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic        overflow,
  input  logic        alu_done,
  input  logic        alu_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] OP_LAST_LEGAL = 4'b1001;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d;   // requester that wins a tie
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        id_q;             // requester owning the operation in flight

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic        gnt_any;
  logic        gnt_id;
  logic        hs;
  logic [3:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic        sel_legal;

  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = prio_q;
    end else begin
      // Only req1 valid -> 1; only req0 valid (or none) -> 0.
      gnt_id = req1_valid;
    end
  end

  // ready is already qualified by valid, so ready high means a handshake.
  // rst is included so that every output reads 0 while reset is held.
  assign req0_ready = ~rst & (state_q == IDLE) & gnt_any & ~gnt_id;
  assign req1_ready = ~rst & (state_q == IDLE) & gnt_any &  gnt_id;
  assign hs         = req0_ready | req1_ready;

  assign sel_op    = gnt_id ? req1_op : req0_op;
  assign sel_a     = gnt_id ? req1_a  : req0_a;
  assign sel_b     = gnt_id ? req1_b  : req0_b;
  assign sel_legal = (sel_op <= OP_LAST_LEGAL);

  // ---------------------------------------------------------------------------
  // EXEC termination
  // ---------------------------------------------------------------------------
  logic exec_done;
  logic exec_tmo;

  assign exec_done = (state_q == EXEC) & alu_done;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  // Counts completed EXEC cycles. It is zero on entry, so reaching TmoLast
  // without alu_done means TIMEOUT_CYCLES cycles have been spent in EXEC.
  logic [TmoW-1:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != EXEC) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign exec_tmo = (state_q == EXEC) & ~alu_done & (tmo_cnt_q == TmoLast);
`else
  assign exec_tmo = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Response source selection
  // ---------------------------------------------------------------------------
  // A response is produced on the cycle that enters RESP. For an illegal op
  // that is the handshake cycle itself, so the owner comes from the live
  // grant rather than from id_q.
  logic        deliver;
  logic        dlv_id;
  logic [31:0] dlv_result, dlv_hi, dlv_lo;
  logic        dlv_ovf, dlv_zero, dlv_err;

  always_comb begin
    deliver    = 1'b0;
    dlv_id     = id_q;
    dlv_result = '0;
    dlv_hi     = '0;
    dlv_lo     = '0;
    dlv_ovf    = 1'b0;
    dlv_zero   = 1'b0;
    dlv_err    = 1'b0;
    if (hs && !sel_legal) begin
      deliver = 1'b1;
      dlv_id  = gnt_id;
      dlv_err = 1'b1;
    end else if (exec_done) begin
      deliver    = 1'b1;
      dlv_result = alu_result;
      dlv_hi     = hi;
      dlv_lo     = lo;
      dlv_ovf    = overflow;
      dlv_zero   = alu_zero;
    end else if (exec_tmo) begin
      deliver = 1'b1;
      dlv_err = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = sel_legal ? EXEC : RESP;
          prio_d  = ~gnt_id;
        end
      end
      EXEC: begin
        if (exec_done || exec_tmo) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // The request is captured once; the requester inputs are not looked at
  // again until the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (hs) begin
      op_q <= sel_op;
      a_q  <= sel_a;
      b_q  <= sel_b;
      id_q <= gnt_id;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU drive
  // ---------------------------------------------------------------------------
  assign alu_en      = (state_q == EXEC);
  assign alu_control = op_q;
  assign alu_srcA    = a_q;
  assign alu_srcB    = b_q;

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  // Each requester has its own data registers, so a requester keeps its last
  // response while the other one is being served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid    <= 1'b0;
      rsp0_result   <= '0;
      rsp0_hi       <= '0;
      rsp0_lo       <= '0;
      rsp0_overflow <= 1'b0;
      rsp0_zero     <= 1'b0;
      rsp0_err      <= 1'b0;
    end else begin
      rsp0_valid <= deliver & ~dlv_id;
      if (deliver && !dlv_id) begin
        rsp0_result   <= dlv_result;
        rsp0_hi       <= dlv_hi;
        rsp0_lo       <= dlv_lo;
        rsp0_overflow <= dlv_ovf;
        rsp0_zero     <= dlv_zero;
        rsp0_err      <= dlv_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid    <= 1'b0;
      rsp1_result   <= '0;
      rsp1_hi       <= '0;
      rsp1_lo       <= '0;
      rsp1_overflow <= 1'b0;
      rsp1_zero     <= 1'b0;
      rsp1_err      <= 1'b0;
    end else begin
      rsp1_valid <= deliver & dlv_id;
      if (deliver && dlv_id) begin
        rsp1_result   <= dlv_result;
        rsp1_hi       <= dlv_hi;
        rsp1_lo       <= dlv_lo;
        rsp1_overflow <= dlv_ovf;
        rsp1_zero     <= dlv_zero;
        rsp1_err      <= dlv_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_one_ready : assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));
  a_one_rsp : assert property (@(posedge clk) disable iff (rst)
    !(rsp0_valid && rsp1_valid));
  a_rsp_in_resp : assert property (@(posedge clk) disable iff (rst)
    (rsp0_valid || rsp1_valid) |-> (state_q == RESP));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A behavioural ALU model raises
// alu_done a programmable number of cycles after alu_en rises. All expected
// values are hand-computed constants.
module tb_alu_arbiter;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned Tmo = 8;
`else
  localparam int unsigned Tmo = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_overflow, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_overflow, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_result, rsp0_hi, rsp0_lo, rsp1_result, rsp1_hi, rsp1_lo;
  logic        alu_en;
  logic [3:0]  alu_control;
  logic [31:0] alu_srcA, alu_srcB;
  logic [31:0] m_result, m_hi, m_lo;
  logic        m_ovf, m_done, m_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.TIMEOUT_CYCLES(Tmo)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_hi(rsp0_hi),
    .rsp0_lo(rsp0_lo), .rsp0_overflow(rsp0_overflow), .rsp0_zero(rsp0_zero),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_hi(rsp1_hi),
    .rsp1_lo(rsp1_lo), .rsp1_overflow(rsp1_overflow), .rsp1_zero(rsp1_zero),
    .rsp1_err(rsp1_err),
    .alu_en(alu_en), .alu_control(alu_control), .alu_srcA(alu_srcA),
    .alu_srcB(alu_srcB),
    .alu_result(m_result), .hi(m_hi), .lo(m_lo), .overflow(m_ovf),
    .alu_done(m_done), .alu_zero(m_zero)
  );

  // ALU model. Codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 8 MULT, 9 DIV.
  int m_delay    = 1;
  bit m_never    = 1'b0;
  bit force_done = 1'b0;
  int m_cnt      = 0;

  always @(posedge clk) begin
    if (!alu_en) m_cnt <= 0;
    else         m_cnt <= m_cnt + 1;
  end

  always_comb begin
    logic [63:0] prod;
    prod     = 64'(alu_srcA) * 64'(alu_srcB);
    m_result = '0;
    m_hi     = '0;
    m_lo     = '0;
    m_ovf    = 1'b0;
    case (alu_control)
      4'd0: m_result = alu_srcA + alu_srcB;
      4'd1: m_result = alu_srcA - alu_srcB;
      4'd2: m_result = alu_srcA & alu_srcB;
      4'd3: m_result = alu_srcA | alu_srcB;
      4'd8: begin m_hi = prod[63:32]; m_lo = prod[31:0]; m_result = prod[31:0]; end
      4'd9: if (alu_srcB != 0) begin
        m_lo = alu_srcA / alu_srcB; m_hi = alu_srcA % alu_srcB; m_result = m_lo;
      end
      default: m_result = '0;
    endcase
    m_zero = (m_result == 32'd0);
  end

  assign m_done = (alu_en && !m_never && (m_cnt == m_delay)) || force_done;

  // Event monitors.
  int rsp0_cnt = 0, rsp1_cnt = 0, en_cnt = 0, both_ready = 0;
  always @(posedge clk) begin
    if (rsp0_valid) rsp0_cnt <= rsp0_cnt + 1;
    if (rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
    if (alu_en) en_cnt <= en_cnt + 1;
    if (req0_ready && req1_ready) both_ready <= both_ready + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  // Called at a negedge with the request already driven. Returns at the
  // negedge of the first cycle after the handshake, with valid dropped.
  task automatic wait_hs(input int id, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " handshake"}, 64'(seen), 64'd1);
    @(negedge clk);
    drop_req(id);
  endtask

  // Polls rspN_valid at negedges; lat = number of cycles waited, -1 if none.
  task automatic wait_rsp(input int id, input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      if ((id == 0 && rsp0_valid) || (id == 1 && rsp1_valid)) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, r1, e0;
    bit early;
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

    // Reset state, with req0 requesting while reset is held.
    @(negedge clk);
    drive_req(0, 4'd0, 32'd1, 32'd1);
    #1;
    check("rst ready0", 64'(req0_ready), 64'd0);
    check("rst alu_en", 64'(alu_en), 64'd0);
    check("rst rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst rsp0_result", 64'(rsp0_result), 64'd0);
    check("rst alu_control", 64'(alu_control), 64'd0);
    do_reset();

    // ADD 15+10 on req0, done one cycle after en.
    m_delay = 1;
    drive_req(0, 4'd0, 32'd15, 32'd10);
    wait_hs(0, "add");
    check("add alu_en T+1", 64'(alu_en), 64'd1);
    check("add srcA", 64'(alu_srcA), 64'd15);
    check("add srcB", 64'(alu_srcB), 64'd10);
    wait_rsp(0, 10, lat);
    check("add latency", 64'(lat), 64'd2);
    check("add result", 64'(rsp0_result), 64'd25);
    check("add zero", 64'(rsp0_zero), 64'd0);
    check("add err", 64'(rsp0_err), 64'd0);
    check("add rsp1_valid", 64'(rsp1_valid), 64'd0);
    @(negedge clk);
    check("add pulse one cycle", 64'(rsp0_valid), 64'd0);
    check("add result held", 64'(rsp0_result), 64'd25);
    check("add alu_en low", 64'(alu_en), 64'd0);
    check("add rsp0 count", 64'(rsp0_cnt), 64'd1);
    check("add rsp1 count", 64'(rsp1_cnt), 64'd0);

    // alu_done in IDLE is ignored.
    force_done = 1'b1;
    repeat (2) @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("idle done ignored", 64'(rsp0_cnt + rsp1_cnt), 64'd1);

    // Round-robin after reset: both valid, req0 first.
    do_reset();
    drive_req(0, 4'd1, 32'd25, 32'd10);
    drive_req(1, 4'd2, 32'b1100, 32'b1010);
    #1;
    check("rr ready0", 64'(req0_ready), 64'd1);
    check("rr ready1", 64'(req1_ready), 64'd0);
    wait_hs(0, "rr sub");
    check("rr ready1 in exec", 64'(req1_ready), 64'd0);
    wait_rsp(0, 10, lat);
    check("rr sub result", 64'(rsp0_result), 64'd15);
    wait_hs(1, "rr and");
    wait_rsp(1, 10, lat);
    check("rr and result", 64'(rsp1_result), 64'd8);
    check("rr sub held", 64'(rsp0_result), 64'd15);
    @(negedge clk);

    // Illegal op: no ALU activity, err response.
    e0 = en_cnt;
    drive_req(0, 4'b1111, 32'd5, 32'd5);
    wait_hs(0, "illegal");
    check("illegal alu_en", 64'(alu_en), 64'd0);
    wait_rsp(0, 3, lat);
    check("illegal within two cycles", 64'(lat >= 0 && lat <= 1), 64'd1);
    check("illegal err", 64'(rsp0_err), 64'd1);
    check("illegal result", 64'(rsp0_result), 64'd0);
    check("illegal hi", 64'(rsp0_hi), 64'd0);
    @(negedge clk);
    check("illegal en never", 64'(en_cnt - e0), 64'd0);

    // MULT 131072*131072 on req1 over 32 cycles; req0 waits until after RESP.
    m_delay = 32;
    drive_req(1, 4'd8, 32'd131072, 32'd131072);
    wait_hs(1, "mult");
    drive_req(0, 4'd0, 32'd1, 32'd2);
    early = 1'b0;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (req0_ready) early = 1'b1;
      if (rsp1_valid) begin lat = k; break; end
      @(negedge clk);
    end
    check("mult req0 held off", 64'(early), 64'd0);
    check("mult latency", 64'(lat), 64'd33);
    check("mult hi", 64'(rsp1_hi), 64'd4);
    check("mult lo", 64'(rsp1_lo), 64'd0);
    check("mult err", 64'(rsp1_err), 64'd0);
    m_delay = 1;
    @(negedge clk);
    wait_hs(0, "post-mult add");
    wait_rsp(0, 10, lat);
    check("post-mult add result", 64'(rsp0_result), 64'd3);
    @(negedge clk);

    // Reset mid-EXEC of DIV 20/3.
    m_delay = 10;
    drive_req(0, 4'd9, 32'd20, 32'd3);
    wait_hs(0, "div");
    repeat (3) @(negedge clk);
    #1;
    check("div in exec", 64'(alu_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("div rst alu_en", 64'(alu_en), 64'd0);
    check("div rst rsp0_result", 64'(rsp0_result), 64'd0);
    check("div rst rsp1_hi", 64'(rsp1_hi), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    r0 = rsp0_cnt;
    repeat (15) @(negedge clk);
    check("div discarded", 64'(rsp0_cnt - r0), 64'd0);
    check("div idle alu_en", 64'(alu_en), 64'd0);
    m_delay = 1;
    drive_req(0, 4'd0, 32'd7, 32'd6);
    wait_hs(0, "add after rst");
    wait_rsp(0, 10, lat);
    check("add after rst result", 64'(rsp0_result), 64'd13);
    @(negedge clk);

    // ALU never completes.
    m_never = 1'b1;
    e0 = en_cnt;
    r1 = rsp1_cnt;
    drive_req(1, 4'd0, 32'd1, 32'd1);
    wait_hs(1, "stall");
`ifdef ALU_ARB_TIMEOUT_EN
    wait_rsp(1, 20, lat);
    check("tmo latency", 64'(lat), 64'd8);
    check("tmo err", 64'(rsp1_err), 64'd1);
    check("tmo result", 64'(rsp1_result), 64'd0);
    check("tmo hi", 64'(rsp1_hi), 64'd0);
    check("tmo zero", 64'(rsp1_zero), 64'd0);
    @(negedge clk);
    check("tmo en cycles", 64'(en_cnt - e0), 64'd8);
`else
    repeat (20) @(negedge clk);
    check("stall alu_en held", 64'(alu_en), 64'd1);
    check("stall no rsp", 64'(rsp1_cnt - r1), 64'd0);
`endif
    m_never = 1'b0;
    do_reset();
    #1;
    check("final alu_en", 64'(alu_en), 64'd0);
    check("ready never both", 64'(both_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
